// File: rtl/shift_unit_iter.sv
// -----------------------------------------------------------------------------
// shift_unit_iter
//   Multi-cycle shift execution unit for the EX stage. It selects the shift
//   amount from a register operand or from the immediate field, then applies
//   SLL / SRL / SRA (and optionally ROTR). Each cycle it shifts by at most
//   STEP_BITS positions. A start/busy/done handshake drives the unit, and a
//   stall output feeds the hazard unit.
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined   : op=11 rotates right (bits leaving the LSB re-enter at the MSB)
//     undefined : op=11 behaves exactly like SRL and no rotate logic is built
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   request a shift (sampled every cycle)
//   flush     in   abort an in-flight op / block a simultaneous start
//   op        in   00 SLL, 01 SRL, 10 SRA, 11 ROTR (or SRL)
//   shift_src in   0: shamt from src_a, 1: shamt from sign_imm field
//   src_a     in   register shift-amount source
//   sign_imm  in   sign-extended immediate
//   src_b     in   value to shift
//   busy      out  high while shifting
//   done      out  one-cycle completion pulse
//   result    out  registered result, held until the next completion
//   stall     out  accepted start or shifting (combinational)
// -----------------------------------------------------------------------------
module shift_unit_iter #(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = 5,
  parameter int STEP_BITS = 8,
  parameter int IMM_LSB   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        op,
  input  logic              shift_src,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] sign_imm,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Step size held one bit wider than the shift amount so STEP_BITS == DATA_W
  // is representable.
  localparam logic [SHAMT_W:0] STEP_MAX = (SHAMT_W+1)'(STEP_BITS);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   value_q;
  logic [1:0]          op_q;
  logic [SHAMT_W-1:0]  remaining_q;

  logic [SHAMT_W-1:0]  shamt_sel;
  logic                accept;
  logic [SHAMT_W:0]    step_k;
  logic [SHAMT_W-1:0]  remaining_next;
  logic [DATA_W-1:0]   value_shifted;

  // One iteration of the selected shift by k positions (k >= 1 in SHIFT).
  function automatic logic [DATA_W-1:0] shift_step(
    input logic [DATA_W-1:0] v,
    input logic [1:0]        o,
    input logic [SHAMT_W:0]  k
  );
    logic signed [DATA_W-1:0] sv;
`ifdef SHIFT_ROTATE_EN
    logic [SHAMT_W:0]         back;
`endif
    sv = v;
    case (o)
      2'b00:   shift_step = v << k;
      // Arithmetic shift of the running value keeps replicating the
      // original sign bit, since the MSB never changes under SRA.
      2'b10:   shift_step = sv >>> k;
`ifdef SHIFT_ROTATE_EN
      2'b11: begin
        back       = (SHAMT_W+1)'(DATA_W) - k;
        shift_step = (v >> k) | (v << back);
      end
`endif
      default: shift_step = v >> k;
    endcase
  endfunction

  assign shamt_sel = shift_src ? sign_imm[IMM_LSB +: SHAMT_W] : src_a[SHAMT_W-1:0];
  assign accept    = start && !flush && (state == IDLE || state == DONE);

  always_comb begin
    if ({1'b0, remaining_q} > STEP_MAX) step_k = STEP_MAX;
    else                                step_k = {1'b0, remaining_q};
  end

  assign remaining_next = remaining_q - step_k[SHAMT_W-1:0];
  assign value_shifted  = shift_step(value_q, op_q, step_k);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (shamt_sel == '0) ? DONE : SHIFT;
        else        state_next = IDLE;
      end
      SHIFT: begin
        if (flush)                     state_next = IDLE;
        else if (remaining_next == '0) state_next = DONE;
        else                           state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      value_q     <= '0;
      op_q        <= '0;
      remaining_q <= '0;
      result      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        value_q     <= src_b;
        op_q        <= op;
        remaining_q <= shamt_sel;
        if (shamt_sel == '0) result <= src_b;
      end else if (state == SHIFT && !flush) begin
        value_q     <= value_shifted;
        remaining_q <= remaining_next;
        if (remaining_next == '0) result <= value_shifted;
      end
    end
  end

  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);
  assign stall = accept || (state == SHIFT);

endmodule

// File: doc/shift_unit_iter.md
Name: shift_unit_iter

Overview:
- Parametrised multi-cycle shift execution unit for the EX stage.
- Successor to the single-cycle shift-amount mux. It selects the shift amount (register or immediate field), then performs SLL/SRL/SRA (and optional ROTR) iteratively, at most STEP_BITS positions per cycle.
- Provides a start/busy/done handshake and a stall output for the hazard unit.

Parameters:
- DATA_W, 32, operand/result width; power of 2, ≥8.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).
- STEP_BITS, 8, maximum positions shifted per cycle; power of 2, 1..DATA_W.
- IMM_LSB, 6, LSB of the shamt field inside sign_imm.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a shift; sampled each cycle.
- flush  in  1  synchronous abort of an in-flight op.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (see Optional Feature).
- shift_src  in  1  0: shamt = src_a[SHAMT_W-1:0]; 1: shamt = sign_imm[IMM_LSB+SHAMT_W-1:IMM_LSB].
- src_a  in  DATA_W  register shift-amount source.
- sign_imm  in  DATA_W  sign-extended immediate.
- src_b  in  DATA_W  value to shift.
- busy  out  1  high while state==SHIFT.
- done  out  1  one-cycle pulse; result valid.
- result  out  DATA_W  registered result; held until the next completion.
- stall  out  1  combinational: accepted start OR state==SHIFT.

Behaviour:
- Reset is synchronous, active-high, on port reset; single clock on port clock.
- Reset state: IDLE; busy=0, done=0, result=0, internal value/remaining/op=0. Reset has priority over flush and start.
- Reset mid-operation: the op is abandoned; no done pulse; result returns to 0.
- FSM states: IDLE, SHIFT, DONE.
- Start is accepted only in IDLE or DONE (back-to-back permitted). Start in SHIFT is ignored and not queued.
- On accept:
  - latch value=src_b, op, remaining=selected shamt (operand sampled in the start cycle only).
  - remaining==0 → next state DONE with result=src_b.
  - otherwise → SHIFT.
- SHIFT, each cycle:
  - k = min(remaining, STEP_BITS); value shifted by k per op.
  - SRA fills with the original sign bit; SLL/SRL fill with 0.
  - remaining -= k.
  - If the new remaining==0: result←shifted value, next state DONE.
- DONE: done=1 for exactly this cycle.
  - Next state is SHIFT/DONE if a start is accepted, otherwise IDLE.
- Latency: start accepted at cycle T → done at T + 1 + ceil(shamt/STEP_BITS). shamt=0 gives 1 cycle; shamt=31 with STEP_BITS=8 gives 5 cycles.
- stall is high from the accept cycle through the last SHIFT cycle; low in the DONE cycle.
- flush:
  - In SHIFT: next state IDLE, no done, result unchanged.
  - In IDLE/DONE: suppresses acceptance of a simultaneous start.
  - Flush wins over start in the same cycle.
- Shift amounts are always < DATA_W by width; no overflow case exists.
- The remaining counter is SHAMT_W bits and never wraps.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: op=11 performs rotate-right (ROTR/ROTRV); bits leaving LSB re-enter at MSB each step.
- Undefined: op=11 decodes identically to SRL (01); no rotate logic is synthesised.

Test Plan:
- SLL with shift_src=1, sign_imm=0x0000_0000, src_b=0x1234_5678, start at T0 → stall=1 at T0 only, done=1 at T1, result=0x1234_5678.
- SRA with shift_src=0, src_a=0x0000_0014, src_b=0x8000_0000 → busy T1–T3, done at T4, result=0xFFFF_F800.
- SRL with shift_src=1, sign_imm=0x0000_07C0 (shamt 31), src_b=0xFFFF_FFFF → done at T5, result=0x0000_0001. A second start asserted at T2 is ignored (no extra done).
- Prior result 0xA5A5_A5A5; SLL shamt 20 started, flush=1 at T2 → state IDLE at T3, done never pulses, result stays 0xA5A5_A5A5.
- op=11, src_b=0x0000_00F1, shamt 4 → with SHIFT_ROTATE_EN result=0x1000_000F; without it result=0x0000_000F.
- Reset=1 at T2 of an SRL shamt 24 op (start again asserted at T2) → T3: busy=0, done=0, result=0, IDLE. A fresh start at T3 completes normally.
